// File: rtl/sd_cmd_engine.sv
// SD/SDIO command-line engine: serialises a 48-bit command with a live CRC7 on a divided sd_clk,
// then captures and checks a 48- or 136-bit response, with a start-bit timeout and NCC idle clocks.
module sd_cmd_engine #(
  parameter int CLK_DIV      = 2,
  parameter int INIT_CLKS    = 80,
  parameter int RESP_TIMEOUT = 64,
  parameter int NCC_CLKS     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         init_req,
  input  logic         cmd_start,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_arg,
  input  logic [1:0]   resp_type,
  input  logic         resp_crc,
  input  logic         cmd_in,
  output logic         sd_clk,
  output logic         cmd_out,
  output logic         cmd_oe,
  output logic         busy,
  output logic         done,
  output logic         timeout,
  output logic         crc_err,
  output logic [135:0] resp
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [15:0]      INIT_N   = 16'(INIT_CLKS);
  localparam logic [15:0]      TO_LAST  = 16'(RESP_TIMEOUT - 1);
  localparam logic [15:0]      NCC_N    = 16'(NCC_CLKS);

  typedef enum logic [2:0] {IDLE, INIT, SEND, WAIT, RECV, NCC} state_t;

  state_t             state_reg, state_next;
  logic [DIV_W-1:0]   div_reg, div_next;
  logic               sd_clk_reg, sd_clk_next;
  logic               cmd_out_reg, cmd_out_next;
  logic               cmd_oe_reg, cmd_oe_next;
  logic               done_reg, done_next;
  logic               timeout_reg, timeout_next;
  logic               crc_err_reg, crc_err_next;
  logic [135:0]       resp_reg, resp_next;
  logic [39:0]        tx_reg, tx_next;
  logic [5:0]         tx_cnt_reg, tx_cnt_next;
  logic [6:0]         tx_crc_reg, tx_crc_next;
  logic [7:0]         rx_cnt_reg, rx_cnt_next;
  logic [6:0]         rx_crc_reg, rx_crc_next;
  logic [15:0]        cnt_reg, cnt_next;
  logic               has_resp_reg, has_resp_next;
  logic               long_reg, long_next;
  logic               chk_crc_reg, chk_crc_next;

  logic               tick, rise, fall, rx_in_crc, rx_last;
  logic [135:0]       resp_shift;

  // One serial CRC7 step, generator x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    return {c[5:0], 1'b0} ^ ({7{b ^ c[6]}} & 7'h09);
  endfunction

  assign busy       = (state_reg != IDLE);
  assign tick       = busy && (div_reg == DIV_LAST);
  assign rise       = tick && !sd_clk_reg;
  assign fall       = tick && sd_clk_reg;
  assign resp_shift = {resp_reg[134:0], cmd_in};
  // R2 covers bits [127:8]; short responses cover the first 40 bits received.
  assign rx_in_crc  = long_reg ? (rx_cnt_reg >= 8'd8 && rx_cnt_reg < 8'd128) : (rx_cnt_reg < 8'd40);
  assign rx_last    = (rx_cnt_reg == (long_reg ? 8'd135 : 8'd47));

  always_comb begin
    state_next    = state_reg;
    div_next      = div_reg;
    sd_clk_next   = sd_clk_reg;
    cmd_out_next  = cmd_out_reg;
    cmd_oe_next   = cmd_oe_reg;
    done_next     = 1'b0;
    timeout_next  = timeout_reg;
    crc_err_next  = crc_err_reg;
    resp_next     = resp_reg;
    tx_next       = tx_reg;
    tx_cnt_next   = tx_cnt_reg;
    tx_crc_next   = tx_crc_reg;
    rx_cnt_next   = rx_cnt_reg;
    rx_crc_next   = rx_crc_reg;
    cnt_next      = cnt_reg;
    has_resp_next = has_resp_reg;
    long_next     = long_reg;
    chk_crc_next  = chk_crc_reg;

    if (!busy) begin
      div_next    = '0;
      sd_clk_next = 1'b0;
    end else if (tick) begin
      div_next    = '0;
      sd_clk_next = !sd_clk_reg;
    end else begin
      div_next    = div_reg + 1'b1;
    end

    case (state_reg)
      IDLE: begin
        cmd_oe_next  = 1'b0;
        cmd_out_next = 1'b1;
        if (init_req || cmd_start) begin
          timeout_next = 1'b0;
          crc_err_next = 1'b0;
          resp_next    = '0;
          cnt_next     = '0;
        end
        if (init_req) begin
          state_next  = INIT;
          cmd_oe_next = 1'b1;
        end else if (cmd_start) begin
          state_next    = SEND;
          tx_next       = {2'b01, cmd_index, cmd_arg};
          tx_cnt_next   = '0;
          tx_crc_next   = '0;
          has_resp_next = (resp_type == 2'd1) || (resp_type == 2'd2);
          long_next     = (resp_type == 2'd2);
          chk_crc_next  = resp_crc;
        end
      end
      INIT: begin
        if (rise && cnt_reg < INIT_N) cnt_next = cnt_reg + 1'b1;
        // Finish on the falling edge so sd_clk parks low.
        if (fall && cnt_reg == INIT_N) begin
          state_next  = IDLE;
          done_next   = 1'b1;
          cmd_oe_next = 1'b0;
        end
      end
      SEND: begin
        if (fall) begin
          if (tx_cnt_reg == 6'd48) begin
            cmd_oe_next  = 1'b0;
            cmd_out_next = 1'b1;
            cnt_next     = '0;
            state_next   = has_resp_reg ? WAIT : NCC;
          end else begin
            cmd_oe_next = 1'b1;
            tx_cnt_next = tx_cnt_reg + 1'b1;
            if (tx_cnt_reg < 6'd40) begin
              cmd_out_next = tx_reg[39];
              tx_next      = {tx_reg[38:0], 1'b0};
              tx_crc_next  = crc7_step(tx_crc_reg, tx_reg[39]);
            end else if (tx_cnt_reg < 6'd47) begin
              cmd_out_next = tx_crc_reg[6];
              tx_crc_next  = {tx_crc_reg[5:0], 1'b0};
            end else begin
              cmd_out_next = 1'b1;
            end
          end
        end
      end
      WAIT: begin
        if (rise) begin
          if (!cmd_in) begin
            state_next  = RECV;
            resp_next   = resp_shift;
            rx_cnt_next = 8'd1;
            rx_crc_next = '0;
          end else if (cnt_reg == TO_LAST) begin
            timeout_next = 1'b1;
            cnt_next     = '0;
            state_next   = NCC;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      RECV: begin
        if (rise) begin
          resp_next   = resp_shift;
          rx_cnt_next = rx_cnt_reg + 1'b1;
          if (rx_in_crc) rx_crc_next = crc7_step(rx_crc_reg, cmd_in);
          // The final bit is the end bit, so the CRC is complete here.
          if (rx_last) begin
            crc_err_next = (chk_crc_reg && (rx_crc_reg != resp_shift[7:1])) || !cmd_in;
            cnt_next     = '0;
            state_next   = NCC;
          end
        end
      end
      NCC: begin
        cmd_oe_next = 1'b0;
        if (rise && cnt_reg < NCC_N) cnt_next = cnt_reg + 1'b1;
        if (fall && cnt_reg == NCC_N) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      div_reg      <= '0;
      sd_clk_reg   <= 1'b0;
      cmd_out_reg  <= 1'b1;
      cmd_oe_reg   <= 1'b0;
      done_reg     <= 1'b0;
      timeout_reg  <= 1'b0;
      crc_err_reg  <= 1'b0;
      resp_reg     <= '0;
      tx_reg       <= '0;
      tx_cnt_reg   <= '0;
      tx_crc_reg   <= '0;
      rx_cnt_reg   <= '0;
      rx_crc_reg   <= '0;
      cnt_reg      <= '0;
      has_resp_reg <= 1'b0;
      long_reg     <= 1'b0;
      chk_crc_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      div_reg      <= div_next;
      sd_clk_reg   <= sd_clk_next;
      cmd_out_reg  <= cmd_out_next;
      cmd_oe_reg   <= cmd_oe_next;
      done_reg     <= done_next;
      timeout_reg  <= timeout_next;
      crc_err_reg  <= crc_err_next;
      resp_reg     <= resp_next;
      tx_reg       <= tx_next;
      tx_cnt_reg   <= tx_cnt_next;
      tx_crc_reg   <= tx_crc_next;
      rx_cnt_reg   <= rx_cnt_next;
      rx_crc_reg   <= rx_crc_next;
      cnt_reg      <= cnt_next;
      has_resp_reg <= has_resp_next;
      long_reg     <= long_next;
      chk_crc_reg  <= chk_crc_next;
    end
  end

  assign sd_clk  = sd_clk_reg;
  assign cmd_out = cmd_out_reg;
  assign cmd_oe  = cmd_oe_reg;
  assign done    = done_reg;
  assign timeout = timeout_reg;
  assign crc_err = crc_err_reg;
  assign resp    = resp_reg;

endmodule
